// File: rtl/peak_decim_rle_if.sv
// Bus bundle for peak_decim_rle: sample/control inputs and the registered output word.
interface peak_decim_rle_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CH_N    = 2,
    parameter int unsigned DECIM_W = 16
) ();
    logic [CH_N*DATA_W-1:0] DATA_IN;
    logic [DATA_W-1:0]      LA_IN;
    logic                   EN;
    logic [1:0]             MODE;
    logic [DECIM_W-1:0]     DECIM;
    logic                   START;
    logic                   FLUSH;
    logic [3:0]             SYNC_SEL;
    logic [CH_N*DATA_W-1:0] OUT_DATA;
    logic                   OUT_VALID;
    logic                   OUT_TAG;
    logic [DATA_W-1:0]      SYNC_OUT;

    modport master (
        output DATA_IN, LA_IN, EN, MODE, DECIM, START, FLUSH, SYNC_SEL,
        input  OUT_DATA, OUT_VALID, OUT_TAG, SYNC_OUT
    );

    modport slave (
        input  DATA_IN, LA_IN, EN, MODE, DECIM, START, FLUSH, SYNC_SEL,
        output OUT_DATA, OUT_VALID, OUT_TAG, SYNC_OUT
    );
endinterface

// File: rtl/peak_decim_rle.sv
// Multi-channel capture front end: pass-through, min/max peak decimation, or
// run-length encoding of the logic-analyser input, plus a registered trigger tap.
module peak_decim_rle #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CH_N    = 2,
    parameter int unsigned DECIM_W = 16
) (
    input logic            CLK,
    input logic            RST,
    peak_decim_rle_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_EMIT2} state_t;
    typedef logic [CH_N-1:0][DATA_W-1:0] word_t;

    localparam logic [1:0]        MODE_PEAK = 2'd1;
    localparam logic [1:0]        MODE_RLE  = 2'd2;
    localparam logic [DATA_W-1:0] RUN_MAX   = '1;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [DECIM_W-1:0] dlen_q, dlen_d;
    logic [DECIM_W-1:0] cnt_q, cnt_d;
    word_t              max_q, max_d;
    word_t              min_q, min_d;
    word_t              min_hold_q, min_hold_d;
    word_t              out_data_q, out_data_d;
    logic [DATA_W-1:0]  run_val_q, run_val_d;
    logic [DATA_W-1:0]  run_cnt_q, run_cnt_d;
    logic [DATA_W-1:0]  sync_q, sync_d;
    logic               out_valid_q, out_valid_d;
    logic               out_tag_q, out_tag_d;

    word_t              din_c, max_upd_c, min_upd_c, run_word_c;
    logic [DECIM_W-1:0] cnt_inc_c;

    assign din_c         = bus.DATA_IN;
    assign bus.OUT_DATA  = out_data_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_TAG   = out_tag_q;
    assign bus.SYNC_OUT  = sync_q;

    // Running extremes including the current sample; an empty window loads it.
    always_comb begin
        max_upd_c  = max_q;
        min_upd_c  = min_q;
        run_word_c = '0;
        for (int k = 0; k < int'(CH_N); k++) begin
            if (cnt_q == '0 || din_c[k] > max_q[k]) max_upd_c[k] = din_c[k];
            if (cnt_q == '0 || din_c[k] < min_q[k]) min_upd_c[k] = din_c[k];
        end
        run_word_c[0] = run_val_q;
        run_word_c[1] = run_cnt_q;
        cnt_inc_c     = cnt_q + DECIM_W'(1);
    end

    // Trigger tap: channel select, anything out of range picks LA_IN.
    always_comb begin
        sync_d = bus.LA_IN;
        for (int k = 0; k < int'(CH_N); k++) begin
            if (bus.SYNC_SEL == 4'(k)) sync_d = din_c[k];
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        dlen_d      = dlen_q;
        cnt_d       = cnt_q;
        max_d       = max_q;
        min_d       = min_q;
        min_hold_d  = min_hold_q;
        out_data_d  = out_data_q;
        run_val_d   = run_val_q;
        run_cnt_d   = run_cnt_q;
        out_valid_d = 1'b0;
        out_tag_d   = 1'b0;

        if (bus.START) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            run_val_d = '0;
            run_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.EN) begin
                        case (bus.MODE)
                            MODE_PEAK: begin
                                mode_d  = MODE_PEAK;
                                dlen_d  = (bus.DECIM < DECIM_W'(2)) ? DECIM_W'(2) : bus.DECIM;
                                max_d   = din_c;
                                min_d   = din_c;
                                cnt_d   = DECIM_W'(1);
                                state_d = S_ACC;
                            end
                            MODE_RLE: begin
                                mode_d    = MODE_RLE;
                                run_val_d = bus.LA_IN;
                                run_cnt_d = DATA_W'(1);
                                state_d   = S_ACC;
                            end
                            default: begin
                                out_data_d  = din_c;
                                out_valid_d = 1'b1;
                            end
                        endcase
                    end
                end

                S_ACC: begin
                    if (mode_q == MODE_PEAK) begin
                        // A window that filled during EMIT2 closes here, like a flush.
                        if (bus.FLUSH || cnt_q == dlen_q) begin
                            cnt_d = '0;
                            if (cnt_q != '0) begin
                                out_data_d  = max_q;
                                out_tag_d   = 1'b1;
                                out_valid_d = 1'b1;
                                min_hold_d  = min_q;
                                state_d     = S_EMIT2;
                            end else begin
                                state_d = S_IDLE;
                            end
                            if (bus.EN) begin
                                max_d = din_c;
                                min_d = din_c;
                                cnt_d = DECIM_W'(1);
                                if (cnt_q == '0) state_d = S_ACC;
                            end
                        end else if (bus.EN) begin
                            max_d = max_upd_c;
                            min_d = min_upd_c;
                            if (cnt_inc_c == dlen_q) begin
                                out_data_d  = max_upd_c;
                                out_tag_d   = 1'b1;
                                out_valid_d = 1'b1;
                                min_hold_d  = min_upd_c;
                                cnt_d       = '0;
                                state_d     = S_EMIT2;
                            end else begin
                                cnt_d = cnt_inc_c;
                            end
                        end
                    end else begin
                        if (bus.FLUSH) begin
                            out_data_d  = run_word_c;
                            out_valid_d = 1'b1;
                            if (bus.EN) begin
                                run_val_d = bus.LA_IN;
                                run_cnt_d = DATA_W'(1);
                            end else begin
                                run_cnt_d = '0;
                                state_d   = S_IDLE;
                            end
                        end else if (bus.EN) begin
                            if (bus.LA_IN == run_val_q && run_cnt_q != RUN_MAX) begin
                                run_cnt_d = run_cnt_q + DATA_W'(1);
                            end else begin
                                out_data_d  = run_word_c;
                                out_valid_d = 1'b1;
                                run_val_d   = bus.LA_IN;
                                run_cnt_d   = DATA_W'(1);
                            end
                        end
                    end
                end

                S_EMIT2: begin
                    out_data_d  = min_hold_q;
                    out_valid_d = 1'b1;
                    if (bus.EN) begin
                        max_d = max_upd_c;
                        min_d = min_upd_c;
                        cnt_d = cnt_inc_c;
                    end
                    state_d = (bus.EN || cnt_q != '0) ? S_ACC : S_IDLE;
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            dlen_q      <= '0;
            cnt_q       <= '0;
            max_q       <= '0;
            min_q       <= '0;
            min_hold_q  <= '0;
            out_data_q  <= '0;
            run_val_q   <= '0;
            run_cnt_q   <= '0;
            sync_q      <= '0;
            out_valid_q <= 1'b0;
            out_tag_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            dlen_q      <= dlen_d;
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            min_q       <= min_d;
            min_hold_q  <= min_hold_d;
            out_data_q  <= out_data_d;
            run_val_q   <= run_val_d;
            run_cnt_q   <= run_cnt_d;
            sync_q      <= sync_d;
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
        end
    end
endmodule

// File: tb/tb_peak_decim_rle.sv
// Directed bench for peak_decim_rle (CH_N=2, DATA_W=8): pass, peak, RLE, START/FLUSH, reset, trigger tap.
module tb_peak_decim_rle;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    int   nv;

    peak_decim_rle_if #(.DATA_W(8), .CH_N(2), .DECIM_W(16)) bus ();

    peak_decim_rle #(.DATA_W(8), .CH_N(2), .DECIM_W(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic en, input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] la);
        bus.EN      = en;
        bus.DATA_IN = {c1, c0};
        bus.LA_IN   = la;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic t, input logic [15:0] d);
        chk({tag, "_valid"}, 32'(bus.OUT_VALID), 32'(v));
        chk({tag, "_tag"},   32'(bus.OUT_TAG),   32'(t));
        chk({tag, "_data"},  32'(bus.OUT_DATA),  32'(d));
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        set_in(1'b0, 8'h00, 8'h00, 8'h00);
        bus.MODE = 2'd0; bus.DECIM = 16'd0; bus.START = 1'b0; bus.FLUSH = 1'b0; bus.SYNC_SEL = 4'd0;
        #2;
        chk_out("reset", 1'b0, 1'b0, 16'h0000);
        chk("reset_sync", 32'(bus.SYNC_OUT), 32'h0);
        step(); step();
        rst = 1'b0;

        // pass mode: one-cycle latency, every cycle valid
        set_in(1'b1, 8'h01, 8'h11, 8'h00); step(); chk_out("pass0", 1'b1, 1'b0, 16'h1101);
        chk("pass0_sync", 32'(bus.SYNC_OUT), 32'h01);
        set_in(1'b1, 8'h02, 8'h22, 8'h00); step(); chk_out("pass1", 1'b1, 1'b0, 16'h2202);
        set_in(1'b1, 8'h03, 8'h33, 8'h00); step(); chk_out("pass2", 1'b1, 1'b0, 16'h3303);
        set_in(1'b1, 8'h04, 8'h44, 8'h00); step(); chk_out("pass3", 1'b1, 1'b0, 16'h4404);
        set_in(1'b0, 8'h05, 8'h55, 8'h00); bus.FLUSH = 1'b1; step(); chk_out("pass_hold", 1'b0, 1'b0, 16'h4404);
        bus.FLUSH = 1'b0;

        // peak DECIM=4: ch0 10,200,3,50  ch1 5,9,1,4
        bus.MODE = 2'd1; bus.DECIM = 16'd4;
        set_in(1'b1, 8'd10, 8'd5, 8'h00);  step(); chk_out("pk4_s1", 1'b0, 1'b0, 16'h4404);
        set_in(1'b1, 8'd200, 8'd9, 8'h00); step();
        set_in(1'b1, 8'd3, 8'd1, 8'h00);   step();
        set_in(1'b1, 8'd50, 8'd4, 8'h00);  step(); chk_out("pk4_max", 1'b1, 1'b1, {8'd9, 8'd200});
        set_in(1'b0, 8'd0, 8'd0, 8'h00);   step(); chk_out("pk4_min", 1'b1, 1'b0, {8'd1, 8'd3});
        step(); chk("pk4_idle_valid", 32'(bus.OUT_VALID), 32'h0);

        // DECIM=0 -> window of 2, back-to-back windows through EMIT2
        bus.DECIM = 16'd0;
        set_in(1'b1, 8'd5, 8'd8, 8'h00); step(); chk("pk0_s1_valid", 32'(bus.OUT_VALID), 32'h0);
        set_in(1'b1, 8'd6, 8'd2, 8'h00); step(); chk_out("pk0_max_a", 1'b1, 1'b1, {8'd8, 8'd6});
        set_in(1'b1, 8'd1, 8'd1, 8'h00); step(); chk_out("pk0_min_a", 1'b1, 1'b0, {8'd2, 8'd5});
        set_in(1'b1, 8'd9, 8'd9, 8'h00); step(); chk_out("pk0_max_b", 1'b1, 1'b1, {8'd9, 8'd9});
        set_in(1'b0, 8'd0, 8'd0, 8'h00); step(); chk_out("pk0_min_b", 1'b1, 1'b0, {8'd1, 8'd1});
        step();

        // DECIM=1 -> window of 2
        bus.DECIM = 16'd1;
        set_in(1'b1, 8'd3, 8'd0, 8'h00); step(); chk("pk1_s1_valid", 32'(bus.OUT_VALID), 32'h0);
        set_in(1'b1, 8'd4, 8'd0, 8'h00); step(); chk_out("pk1_max", 1'b1, 1'b1, {8'd0, 8'd4});
        set_in(1'b0, 8'd0, 8'd0, 8'h00); step(); chk_out("pk1_min", 1'b1, 1'b0, {8'd0, 8'd3});
        step();

        // DECIM=3, START on the max-word cycle suppresses the min word and discards its sample
        bus.DECIM = 16'd3;
        set_in(1'b1, 8'd4, 8'd0, 8'h00); step();
        set_in(1'b1, 8'd8, 8'd0, 8'h00); step();
        set_in(1'b1, 8'd6, 8'd0, 8'h00); step(); chk_out("st_max", 1'b1, 1'b1, {8'd0, 8'd8});
        set_in(1'b1, 8'd100, 8'd0, 8'h00); bus.START = 1'b1; step(); chk_out("st_cancel", 1'b0, 1'b0, {8'd0, 8'd8});
        bus.START = 1'b0;
        set_in(1'b1, 8'd1, 8'd7, 8'h00); step();
        set_in(1'b1, 8'd2, 8'd7, 8'h00); step(); chk("st_w2_open", 32'(bus.OUT_VALID), 32'h0);
        set_in(1'b1, 8'd3, 8'd7, 8'h00); step(); chk_out("st_w2_max", 1'b1, 1'b1, {8'd7, 8'd3});
        set_in(1'b0, 8'd0, 8'd0, 8'h00); step(); chk_out("st_w2_min", 1'b1, 1'b0, {8'd7, 8'd1});
        step();

        // RLE on LA_IN: 5,5,5,7
        bus.MODE = 2'd2;
        set_in(1'b1, 8'h00, 8'h00, 8'd5); step(); chk("rle_open_valid", 32'(bus.OUT_VALID), 32'h0);
        set_in(1'b1, 8'h00, 8'h00, 8'd5); step();
        set_in(1'b1, 8'h00, 8'h00, 8'd5); step(); chk("rle_cnt_valid", 32'(bus.OUT_VALID), 32'h0);
        set_in(1'b1, 8'h00, 8'h00, 8'd7); step(); chk_out("rle_5x3", 1'b1, 1'b0, 16'h0305);

        // 300 x 0xAA: closes the 7-run, saturates at 255, remainder 45 flushed
        nv = 0;
        for (int i = 1; i <= 300; i++) begin
            set_in(1'b1, 8'h00, 8'h00, 8'hAA); step();
            if (i == 1) chk_out("rle_7x1", 1'b1, 1'b0, 16'h0107);
            else if (bus.OUT_VALID) nv++;
            if (i == 256) chk_out("rle_aa255", 1'b1, 1'b0, 16'hFFAA);
        end
        chk("rle_aa_strobes", 32'(nv), 32'd1);
        set_in(1'b0, 8'h00, 8'h00, 8'hAA); bus.FLUSH = 1'b1; step(); chk_out("rle_aa45", 1'b1, 1'b0, 16'h2DAA);
        step(); chk_out("flush_idle", 1'b0, 1'b0, 16'h2DAA);
        bus.FLUSH = 1'b0;

        // run of 4 flushed with a new sample 9 on the same edge
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 8'h00, 8'h00, 8'd3); step();
        end
        chk("rle4_quiet", 32'(bus.OUT_VALID), 32'h0);
        set_in(1'b1, 8'h00, 8'h00, 8'd9); bus.FLUSH = 1'b1; step(); chk_out("rle_3x4", 1'b1, 1'b0, 16'h0403);
        set_in(1'b0, 8'h00, 8'h00, 8'd9); step(); chk_out("rle_9x1", 1'b1, 1'b0, 16'h0109);
        bus.FLUSH = 1'b0;

        // async reset mid-window, trigger tap on LA_IN
        bus.MODE = 2'd1; bus.DECIM = 16'd2; bus.SYNC_SEL = 4'd2;
        set_in(1'b1, 8'd250, 8'd250, 8'h3C); step();
        chk("sync_la", 32'(bus.SYNC_OUT), 32'h3C);
        set_in(1'b0, 8'd0, 8'd0, 8'h3C);
        #3 rst = 1'b1;
        #1;
        chk_out("arst", 1'b0, 1'b0, 16'h0000);
        chk("arst_sync", 32'(bus.SYNC_OUT), 32'h0);
        #1 rst = 1'b0;
        set_in(1'b1, 8'd40, 8'd1, 8'h5A); step();
        chk("post_rst_valid", 32'(bus.OUT_VALID), 32'h0);
        chk("sync_la2", 32'(bus.SYNC_OUT), 32'h5A);
        set_in(1'b1, 8'd50, 8'd2, 8'h5A); bus.SYNC_SEL = 4'd1; step();
        chk_out("post_rst_max", 1'b1, 1'b1, {8'd2, 8'd50});
        chk("sync_ch1", 32'(bus.SYNC_OUT), 32'h02);
        set_in(1'b0, 8'd0, 8'd0, 8'h66); bus.SYNC_SEL = 4'd15; step();
        chk_out("post_rst_min", 1'b1, 1'b0, {8'd1, 8'd40});
        chk("sync_sel15", 32'(bus.SYNC_OUT), 32'h66);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
